// File: rtl/fixed_to_ascii_stream.sv
// ============================================================================
// Module      : fixed_to_ascii_stream
// Description : Converts a signed fixed-point word (scaled by 10^FRAC_DIGITS)
//               into decimal ASCII text, one divide-by-10 per cycle, and
//               streams the bytes over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fixed_to_ascii_stream #(
  parameter int          WIDTH       = 64,
  parameter int          INT_DIGITS  = 6,
  parameter int          FRAC_DIGITS = 6,
  parameter int          SUPPRESS_LZ = 0,
  parameter logic [7:0]  OVF_CHAR    = 8'h23
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_char,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             ovf
);

  localparam int               c_TOTAL    = INT_DIGITS + FRAC_DIGITS;
  localparam int               c_CW       = $clog2(c_TOTAL + 2);
  localparam logic [WIDTH-1:0] c_TEN      = WIDTH'(10);
  localparam logic [c_CW-1:0]  c_CNT_END  = c_CW'(c_TOTAL);
  localparam logic [c_CW-1:0]  c_POS_INT  = c_CW'(INT_DIGITS);
  localparam logic [c_CW-1:0]  c_POS_DOT  = c_CW'(INT_DIGITS + 1);
  localparam logic [c_CW-1:0]  c_POS_LAST = c_CW'(c_TOTAL + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_EMIT = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_sign;
  logic [WIDTH-1:0]       r_mag;
  logic [c_CW-1:0]        r_cnt;
  logic [c_CW-1:0]        r_pos;      // position within the unsuppressed frame
  logic [4*c_TOTAL-1:0]   r_digits;   // BCD, digit 0 = least significant fraction digit
  logic                   r_ovf;

  logic [WIDTH-1:0]       w_abs;
  logic [WIDTH-1:0]       w_quo;
  logic [WIDTH-1:0]       w_rem;
  logic [c_CW-1:0]        w_lz;
  logic                   w_seen;
  logic                   w_skip;
  logic [c_CW-1:0]        w_idx;
  logic [3:0]             w_dig;
  logic                   w_accept;
  logic                   w_xfer;

  // Magnitude as unsigned WIDTH bits; the most-negative input maps to 2^(WIDTH-1)
  assign w_abs    = in_data[WIDTH-1] ? (~in_data + WIDTH'(1)) : in_data;
  assign w_quo    = r_mag / c_TEN;
  assign w_rem    = r_mag % c_TEN;
  assign w_accept = (r_state == S_IDLE) && in_valid;
  assign w_xfer   = (r_state == S_EMIT) && out_ready;
  assign w_skip   = (SUPPRESS_LZ != 0) && !r_ovf;
  assign ovf      = r_ovf;

  // Count leading zero integer digits above the units digit
  always_comb begin
    w_lz   = '0;
    w_seen = 1'b0;
    for (int k = INT_DIGITS - 1; k >= 1; k--) begin
      if (!w_seen && (r_digits[4*(FRAC_DIGITS+k) +: 4] == 4'd0)) begin
        w_lz = w_lz + c_CW'(1);
      end else begin
        w_seen = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and frame byte generation
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    out_char    = 8'h00;
    w_idx       = '0;
    w_dig       = 4'd0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_nxt = S_CONV;
        end
      end
      S_CONV: begin
        if (r_cnt == c_CNT_END) begin
          w_state_nxt = S_EMIT;
        end
      end
      S_EMIT: begin
        out_valid = 1'b1;
        out_last  = (r_pos == c_POS_LAST);
        if (r_pos == '0) begin
          out_char = r_sign ? 8'h2D : 8'h2B;
        end else if (r_pos == c_POS_DOT) begin
          out_char = 8'h2E;
        end else begin
          // Integer positions sit above the point, fraction positions below it
          w_idx    = (r_pos <= c_POS_INT) ? (c_CNT_END - r_pos) : (c_POS_LAST - r_pos);
          w_dig    = r_digits[{w_idx, 2'b00} +: 4];
          out_char = r_ovf ? OVF_CHAR : (8'h30 + {4'h0, w_dig});
        end
        if (out_ready && (r_pos == c_POS_LAST)) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: latch input, divide-by-10 conversion, output position stepping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign   <= 1'b0;
      r_mag    <= '0;
      r_cnt    <= '0;
      r_pos    <= '0;
      r_digits <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sign <= in_data[WIDTH-1];
        r_mag  <= w_abs;
        r_cnt  <= '0;
        r_ovf  <= 1'b0;
      end else if (r_state == S_CONV) begin
        if (r_cnt != c_CNT_END) begin
          r_digits[{r_cnt, 2'b00} +: 4] <= w_rem[3:0];
          r_mag                         <= w_quo;
          r_cnt                         <= r_cnt + c_CW'(1);
        end else begin
          // Any magnitude left after all digits means the value does not fit
          r_ovf <= (r_mag != '0);
          r_pos <= '0;
        end
      end else if (w_xfer) begin
        if (r_pos == '0) begin
          r_pos <= c_CW'(1) + (w_skip ? w_lz : '0);
        end else begin
          r_pos <= r_pos + c_CW'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire
